if_fetch_unit: RTL

//   Instruction-fetch stage. Owns the PC, issues word fetches to instruction memory over a
//   req/ready + rvalid handshake, and presents IF_Instruction/IF_PC to the IF/ID register.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/if_fetch_buffer.sv | 48 ++++
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch stage. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer : one-entry output buffer feeding the IF/ID register. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module if_fetch_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic        consume,
   input  logic [31:0] load_inst,
   input  logic [31:0] load_pc,
   output logic        ob_valid,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   logic [31:0] ob_inst;
   logic [31:0] ob_pc;

   // Flush wins over load so a squashed cycle can never capture wrong-path data.
   always_ff @(posedge clk) begin
      if (reset) begin
         ob_valid <= 1'b0;
         ob_inst  <= NOP_INST;
         ob_pc    <= 32'h0;
      end else if (flush) begin
         ob_valid <= 1'b0;
      end else if (load) begin
         ob_valid <= 1'b1;
         ob_inst  <= load_inst;
         ob_pc    <= load_pc;
      end else if (consume) begin
         ob_valid <= 1'b0;
      end
   end

   assign if_valid       = ob_valid & ~reset;
   assign if_instruction = if_valid ? ob_inst : NOP_INST;
   assign if_pc          = if_valid ? ob_pc   : 32'h0;

endmodule : if_fetch_buffer

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit : PC, imem req/rvalid handshake and redirect; option FETCH_PERF_CNT_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_IF_ID,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC,
   output logic        IF_valid
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0] perf_bubble_cnt
`endif
);

   fetch_state_t state, state_n;
   logic [31:0]  fetch_pc, fetch_pc_n;
   logic [31:0]  inflight_pc, inflight_pc_n;
   logic         kill, kill_n;
   logic         ob_valid;
   logic         consume;
   logic         handshake;
   logic         buf_load;

   assign consume   = ob_valid & ~stall_IF_ID;
   assign imem_req  = ~reset & (state == S_REQ) & (~ob_valid | consume) & ~redirect_valid;
   assign handshake = imem_req & imem_ready;
   assign imem_addr = reset ? 32'h0 : fetch_pc;

   always_comb begin
      state_n       = state;
      fetch_pc_n    = fetch_pc;
      inflight_pc_n = inflight_pc;
      kill_n        = kill;
      buf_load      = 1'b0;

      case (state)
         S_REQ: begin
            if (handshake) begin
               state_n       = S_WAIT;
               inflight_pc_n = fetch_pc;
               fetch_pc_n    = fetch_pc + PC_STEP;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_n = S_REQ;
               if (kill) begin
                  kill_n = 1'b0;
               end else begin
                  buf_load = ~redirect_valid;
               end
            end
         end
         default: begin
            state_n = S_REQ;
         end
      endcase

      // A redirect overrides everything above; the response of an outstanding
      // request is either dropped now or marked for dropping via kill.
      if (redirect_valid) begin
         fetch_pc_n = word_align(redirect_pc);
         buf_load   = 1'b0;
         if (state == S_WAIT) begin
            kill_n = ~imem_rvalid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_REQ;
         fetch_pc    <= RESET_PC;
         inflight_pc <= 32'h0;
         kill        <= 1'b0;
      end else begin
         state       <= state_n;
         fetch_pc    <= fetch_pc_n;
         inflight_pc <= inflight_pc_n;
         kill        <= kill_n;
      end
   end

   if_fetch_buffer u_buffer (
      .clk            (clk),
      .reset          (reset),
      .load           (buf_load),
      .flush          (redirect_valid),
      .consume        (consume),
      .load_inst      (imem_rdata),
      .load_pc        (inflight_pc),
      .ob_valid       (ob_valid),
      .if_instruction (IF_Instruction),
      .if_pc          (IF_PC),
      .if_valid       (IF_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_bubble_cnt <= 32'h0;
      end else if (!IF_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
         perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule : if_fetch_unit

`default_nettype wire
